// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounced press/release, one-cycle key event, packed BCD entry.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_PERIOD     = 10000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] bcd_value
);

    localparam int SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    // The dwell must outlast the 2-flop synchronizer latency.
    generate
        if (SCAN_PERIOD < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("keypad_scanner: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t              state, state_next;
    logic [3:0]          row_s1, row_s2;
    logic [SCAN_W-1:0]   scan_cnt, scan_next;
    logic [DEB_W-1:0]    deb_cnt, deb_next;
    logic [3:0]          col_next;
    logic [1:0]          cap_row, cap_row_next;
    logic [1:0]          cap_col, cap_col_next;
    logic [3:0]          code_next;
    logic                valid_next;
    logic [15:0]         bcd_next;
    logic                emit;
    logic                row_high;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0]    rep_cnt, rep_next;
`endif

    function automatic logic [1:0] col_index(input logic [3:0] c);
        case (c)
            4'b1110: col_index = 2'd0;
            4'b1101: col_index = 2'd1;
            4'b1011: col_index = 2'd2;
            default: col_index = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] lowest_row(input logic [3:0] r);
        if (!r[0])      lowest_row = 2'd0;
        else if (!r[1]) lowest_row = 2'd1;
        else if (!r[2]) lowest_row = 2'd2;
        else            lowest_row = 2'd3;
    endfunction

    function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_lut = 4'd1;   4'h1: key_lut = 4'd2;
            4'h2: key_lut = 4'd3;   4'h3: key_lut = 4'd10;
            4'h4: key_lut = 4'd4;   4'h5: key_lut = 4'd5;
            4'h6: key_lut = 4'd6;   4'h7: key_lut = 4'd11;
            4'h8: key_lut = 4'd7;   4'h9: key_lut = 4'd8;
            4'hA: key_lut = 4'd9;   4'hB: key_lut = 4'd12;
            4'hC: key_lut = 4'd14;  4'hD: key_lut = 4'd0;
            4'hE: key_lut = 4'd15;  default: key_lut = 4'd13;
        endcase
    endfunction

    function automatic logic [15:0] bcd_update(input logic [15:0] bcd, input logic [3:0] code);
        if (code <= 4'd9)        bcd_update = {bcd[11:0], code};
        else if (code == 4'd14)  bcd_update = '0;
        else                     bcd_update = bcd;
    endfunction

    assign row_high = row_s2[cap_row];

    always_comb begin
        state_next   = state;
        scan_next    = scan_cnt;
        deb_next     = deb_cnt;
        col_next     = col_n;
        cap_row_next = cap_row;
        cap_col_next = cap_col;
        code_next    = key_code;
        valid_next   = 1'b0;
        bcd_next     = bcd_value;
        emit         = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_next     = '0;
`endif
        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_next = '0;
                    if (row_s2 != 4'b1111) begin
                        cap_row_next = lowest_row(row_s2);
                        cap_col_next = col_index(col_n);
                        deb_next     = '0;
                        state_next   = DEBOUNCE;
                    end else begin
                        col_next = {col_n[2:0], col_n[3]};
                    end
                end else begin
                    scan_next = scan_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_high) begin
                    state_next = SCAN;
                    col_next   = {col_n[2:0], col_n[3]};
                    deb_next   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    emit       = 1'b1;
                    deb_next   = '0;
                    state_next = HELD;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!row_high) begin
                    deb_next = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rep_cnt == REP_LAST) begin
                        emit = 1'b1;
                    end else begin
                        rep_next = rep_cnt + 1'b1;
                    end
`endif
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = SCAN;
                    col_next   = {col_n[2:0], col_n[3]};
                    deb_next   = '0;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase

        // Repeat events recompute the code from the captured position, so they match the original press.
        if (emit) begin
            valid_next = 1'b1;
            code_next  = key_lut(cap_row, cap_col);
            bcd_next   = bcd_update(bcd_value, code_next);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            row_s1    <= '1;
            row_s2    <= '1;
            scan_cnt  <= '0;
            deb_cnt   <= '0;
            col_n     <= 4'b1110;
            cap_row   <= '0;
            cap_col   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            bcd_value <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_next;
            row_s1    <= row_n;
            row_s2    <= row_s1;
            scan_cnt  <= scan_next;
            deb_cnt   <= deb_next;
            col_n     <= col_next;
            cap_row   <= cap_row_next;
            cap_col   <= cap_col_next;
            key_code  <= code_next;
            key_valid <= valid_next;
            bcd_value <= bcd_next;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= rep_next;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix (pressed key pulls its row low
// only while its column is driven). Auto-repeat checks follow KEYPAD_AUTOREPEAT_EN.
module tb_keypad_scanner;

    localparam int SP = 4;
    localparam int DB = 8;
    localparam int RP = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] bcd_value;

    logic key_down    = 1'b0;
    logic bounce_high = 1'b0;
    int   key_r = 0;
    int   key_c = 0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign row_n = (key_down && !bounce_high && !col_n[key_c]) ? ~(4'b0001 << key_r) : 4'b1111;

    keypad_scanner #(
        .SCAN_PERIOD(SP),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row_n(row_n),
        .col_n(col_n),
        .key_code(key_code),
        .key_valid(key_valid),
        .bcd_value(bcd_value)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_pulse(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (key_valid === 1'b1) n++;
        end
    endtask

    task automatic wait_col(input logic [3:0] target, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (col_n === target) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " col_n"}, col_n, 4'b1110);
        check({tag, " key_code"}, key_code, 4'd0);
        check({tag, " key_valid"}, key_valid, 1'b0);
        check({tag, " bcd"}, bcd_value, 16'h0000);
    endtask

    // Press, check the single event, hold, release, and check the column advances exactly 10 edges later
    // (2 synchronizer cycles + DB release cycles).
    task automatic press(input string tag, input int r, input int c, input logic [3:0] ecode,
                         input logic [15:0] ebcd);
        bit         found;
        int         n;
        int         edges;
        logic [3:0] exp_col;
        logic [3:0] held;
        logic [3:0] next_col;
        key_r = r;
        key_c = c;
        key_down = 1'b1;
        wait_pulse(100, found);
        check({tag, " seen"}, found, 1'b1);
        check({tag, " code"}, key_code, ecode);
        check({tag, " bcd"}, bcd_value, ebcd);
        exp_col = ~(4'b0001 << c);
        check({tag, " col frozen"}, col_n, exp_col);
        @(negedge clk);
        check({tag, " pulse width"}, key_valid, 1'b0);
        count_pulses(10, n);
        check({tag, " held single event"}, n, 0);
        held = col_n;
        next_col = {held[2:0], held[3]};
        key_down = 1'b0;
        edges = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            edges++;
            if (key_valid === 1'b1) n++;
            if (col_n !== held) break;
        end
        check({tag, " release edges"}, edges, 10);
        check({tag, " release next col"}, col_n, next_col);
        check({tag, " release no event"}, n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         found;
        int         n;
        int         first_hit;
        int         last_hit;
        logic [3:0] exp_col;
        logic [3:0] prev;
        int         seq_r[7]    = '{0, 0, 0, 1, 2, 3, 3};
        int         seq_c[7]    = '{0, 1, 2, 0, 2, 3, 0};
        logic [3:0] seq_code[7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd13, 4'd14};
        logic [15:0] seq_bcd[7] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234, 16'h2349, 16'h2349, 16'h0000};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Idle: each column dwells SP cycles, no events.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("idle col k=%0d", k), col_n, exp_col);
            check($sformatf("idle valid k=%0d", k), key_valid, 1'b0);
        end

        press("key5", 1, 1, 4'd5, 16'h0005);
        press("star_clear", 3, 0, 4'd14, 16'h0000);
        for (int i = 0; i < 7; i++)
            press($sformatf("seq%0d", i), seq_r[i], seq_c[i], seq_code[i], seq_bcd[i]);

        // Bounce on '7': enter DEBOUNCE at column 0, then a high read aborts to column 1.
        found = 1'b0;
        prev = col_n;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col_n === 4'b1110 && prev === 4'b0111) begin
                found = 1'b1;
                break;
            end
            prev = col_n;
        end
        check("bounce align", found, 1'b1);
        key_r = 2;
        key_c = 0;
        key_down = 1'b1;
        repeat (4) @(negedge clk);
        check("bounce debounce holds col", col_n, 4'b1110);
        bounce_high = 1'b1;
        @(negedge clk);
        check("bounce sync lag 1", col_n, 4'b1110);
        @(negedge clk);
        check("bounce sync lag 2", col_n, 4'b1110);
        @(negedge clk);
        check("bounce abort next col", col_n, 4'b1101);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            bounce_high = (i % 4 == 3);
            @(negedge clk);
            if (key_valid === 1'b1) n++;
        end
        check("bounce no event", n, 0);
        key_down = 1'b0;
        bounce_high = 1'b0;
        repeat (12) @(negedge clk);
        check("bounce bcd", bcd_value, 16'h0000);

        press("pre9", 2, 2, 4'd9, 16'h0009);

        // Reset during DEBOUNCE of '8'.
        wait_col(4'b1110, 20, found);
        check("deb align col0", found, 1'b1);
        key_r = 2;
        key_c = 1;
        key_down = 1'b1;
        wait_col(4'b1101, 20, found);
        check("deb align col1", found, 1'b1);
        count_pulses(6, n);
        check("deb no early event", n, 0);
        check("deb col held", col_n, 4'b1101);
        reset = 1'b1;
        #1;
        check_reset_values("reset in debounce");
        @(negedge clk);
        check_reset_values("reset in debounce held");
        reset = 1'b0;
        wait_pulse(100, found);
        check("redetect1 seen", found, 1'b1);
        check("redetect1 code", key_code, 4'd8);
        check("redetect1 bcd", bcd_value, 16'h0008);
        count_pulses(12, n);
        check("redetect1 single", n, 0);

        // Reset while HELD.
        reset = 1'b1;
        #1;
        check_reset_values("reset in held");
        @(negedge clk);
        reset = 1'b0;
        wait_pulse(100, found);
        check("redetect2 seen", found, 1'b1);
        check("redetect2 code", key_code, 4'd8);
        check("redetect2 bcd", bcd_value, 16'h0008);
        count_pulses(12, n);
        check("redetect2 single", n, 0);
        key_down = 1'b0;
        repeat (20) @(negedge clk);

        // Hold 'A' for 70 cycles past acceptance.
        key_r = 0;
        key_c = 3;
        key_down = 1'b1;
        wait_pulse(100, found);
        check("keyA seen", found, 1'b1);
        check("keyA code", key_code, 4'd10);
        check("keyA bcd", bcd_value, 16'h0008);
        n = 0;
        first_hit = -1;
        last_hit = -1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                n++;
                if (first_hit < 0) first_hit = k;
                last_hit = k;
            end
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        check("repeat count", n, 3);
        check("repeat first", first_hit, RP);
        check("repeat last", last_hit, 3 * RP);
`else
        check("no repeat count", n, 0);
`endif
        check("keyA hold code", key_code, 4'd10);
        check("keyA hold bcd", bcd_value, 16'h0008);
        key_down = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
